// File: rtl/hex_sched_pkg.sv
// Purpose : shared types and sizes for the hex display scheduler slice.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: NSRC (number of sources), COORD_W (coordinate width),
//           SRC_W (source index width), state_t (scheduler FSM states).
package hex_sched_pkg;

   localparam int NSRC    = 4;
   localparam int COORD_W = 12;
   localparam int SRC_W   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      NEXT = 2'd2
   } state_t;

endpackage : hex_sched_pkg

// File: rtl/rr_next_finder.sv
// Purpose : round-robin search for the next present source after ptr.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   present [NSRC-1:0]  - per-source present flags
//   ptr     [SRC_W-1:0] - search base; candidates are ptr+1, ptr+2, ... ptr
//   nxt     [SRC_W-1:0] - first present candidate (ptr itself checked last);
//                         returns ptr when no flag is set
module rr_next_finder
   import hex_sched_pkg::*;
(
   input  logic [NSRC-1:0]  present,
   input  logic [SRC_W-1:0] ptr,
   output logic [SRC_W-1:0] nxt
);

   logic             found;
   logic [SRC_W-1:0] cand;

   // The index arithmetic wraps naturally in SRC_W bits, so k = NSRC lands
   // back on ptr, which makes ptr the last candidate examined.
   always_comb begin
      nxt   = ptr;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NSRC; k++) begin
         cand = ptr + SRC_W'(k);
         if (!found && present[cand]) begin
            nxt   = cand;
            found = 1'b1;
         end
      end
   end

endmodule : rr_next_finder

// File: rtl/hex_display_scheduler.sv
// Purpose : latch four 12-bit coordinate sources and rotate them onto one hex display.
// Latency : value accepted at an edge is visible on o_coord the next cycle; ack 1 cycle.
// Backpressure: none; every valid is accepted and acked, i_freeze only pauses rotation.
//
// Ports:
//   i_clk            - single clock, all registers on rising edge
//   i_rst            - synchronous active-high reset
//   i_valid [3:0]    - per-source offer strobe
//   i_data  [3:0][11:0] - per-source coordinate value
//   i_freeze         - hold the current source and pause the dwell count
//   o_ack   [3:0]    - per-source one-cycle acknowledge
//   o_coord [11:0]   - value for the downstream three-digit hex decoder
//   o_src   [1:0]    - index of the source on display
//   o_blank          - display driven dark
//
// Build option: define HEX_SCHED_FLASH_EN to blank the display for FLASH_LEN
// cycles whenever the shown value or the shown source changes.
module hex_display_scheduler
   import hex_sched_pkg::*;
#(
   parameter int DWELL     = 50_000_000,
   parameter int FLASH_LEN = 5_000_000
)
(
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NSRC-1:0]                i_valid,
   input  logic [NSRC-1:0][COORD_W-1:0]   i_data,
   input  logic                           i_freeze,
   output logic [NSRC-1:0]                o_ack,
   output logic [COORD_W-1:0]             o_coord,
   output logic [SRC_W-1:0]               o_src,
   output logic                           o_blank
);

   // DWELL-1 must fit the counter; DWELL = 2^26 needs exactly 26 bits.
   localparam int                CNT_W    = $clog2(DWELL);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

   // Elaboration-time range checks on the configuration.
   if (DWELL < 2 || DWELL > (1 << 26)) begin : g_dwell_range
      $error("hex_display_scheduler: DWELL out of range 2..2^26");
   end
   if (FLASH_LEN < 1) begin : g_flash_range
      $error("hex_display_scheduler: FLASH_LEN must be at least 1");
   end

   // ---------------------------------------------------------------
   // Per-source capture: hold registers, present flags, acknowledges
   // ---------------------------------------------------------------
   logic [NSRC-1:0][COORD_W-1:0] hold;
   logic [NSRC-1:0]              present;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold    <= '0;
         present <= '0;
         o_ack   <= '0;
      end else begin
         // Every offer is taken unconditionally, so the ack is simply the
         // registered valid vector.
         o_ack   <= i_valid;
         present <= present | i_valid;
         for (int n = 0; n < NSRC; n++) begin
            if (i_valid[n]) begin
               hold[n] <= i_data[n];
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Rotation FSM
   // ---------------------------------------------------------------
   state_t             state, state_nxt;
   logic [SRC_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [SRC_W-1:0]   find_base;
   logic [SRC_W-1:0]   rr_nxt;
   logic               disp_active;

   // Out of IDLE we want the lowest present index; searching from the top
   // index makes index 0 the first candidate, so one finder serves both the
   // initial pick and the round-robin step.
   assign find_base = (state == IDLE) ? SRC_W'(NSRC - 1) : ptr;

   rr_next_finder u_rr_next_finder (
      .present (present),
      .ptr     (find_base),
      .nxt     (rr_nxt)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      o_coord     = '0;
      o_src       = '0;
      disp_active = 1'b0;

      case (state)
         IDLE: begin
            if (|present) begin
               state_nxt = SHOW;
               ptr_nxt   = rr_nxt;
               cnt_nxt   = '0;
            end
         end
         SHOW: begin
            // The count is left at CNT_LAST on the way out; NEXT clears it.
            if (!i_freeze) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = NEXT;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         NEXT: begin
            state_nxt = SHOW;
            ptr_nxt   = rr_nxt;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
            cnt_nxt   = '0;
         end
      endcase

      // SHOW and NEXT both present the current pointer; the coordinate is
      // read straight from the hold register so a fresh value appears the
      // cycle after it is accepted.
      if (state == SHOW || state == NEXT) begin
         o_coord     = hold[ptr];
         o_src       = ptr;
         disp_active = 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Blanking
   // ---------------------------------------------------------------
`ifdef HEX_SCHED_FLASH_EN
   localparam int FL_W = $clog2(FLASH_LEN + 1);

   logic [FL_W-1:0] flash_cnt;
   logic            flash_load;

   // A new value on the shown source, or a hop to a different source, both
   // change what the viewer sees, so both restart the dark interval.
   assign flash_load = (disp_active && i_valid[ptr]) ||
                       (state == NEXT && rr_nxt != ptr);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         flash_cnt <= '0;
      end else if (flash_load) begin
         flash_cnt <= FL_W'(FLASH_LEN);
      end else if (flash_cnt != '0) begin
         // Deliberately not gated by i_freeze.
         flash_cnt <= flash_cnt - 1'b1;
      end
   end

   assign o_blank = !disp_active || (flash_cnt != '0);
`else
   assign o_blank = !disp_active;
`endif

endmodule : hex_display_scheduler

// File: tb/tb_hex_display_scheduler.sv
// Purpose : scoreboard bench for hex_display_scheduler with DWELL=4, FLASH_LEN=2.
// Latency : expectations are queued per stimulus cycle and checked one cycle later.
// Backpressure: n/a.
module tb_hex_display_scheduler;

`ifdef HEX_SCHED_FLASH_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic              i_clk;
   logic              i_rst;
   logic [3:0]        i_valid;
   logic [3:0][11:0]  i_data;
   logic              i_freeze;
   logic [3:0]        o_ack;
   logic [11:0]       o_coord;
   logic [1:0]        o_src;
   logic              o_blank;

   typedef struct {
      logic [3:0]  ack;
      logic        blank;
      logic [1:0]  src;
      logic [11:0] coord;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   hex_display_scheduler #(
      .DWELL     (4),
      .FLASH_LEN (2)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .i_data   (i_data),
      .i_freeze (i_freeze),
      .o_ack    (o_ack),
      .o_coord  (o_coord),
      .o_src    (o_src),
      .o_blank  (o_blank)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: one expectation per observed cycle, sampled on the falling edge.
   always @(negedge i_clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk(mon_e.name, "ack",   32'(o_ack),   32'(mon_e.ack));
         chk(mon_e.name, "blank", 32'(o_blank), 32'(mon_e.blank));
         chk(mon_e.name, "src",   32'(o_src),   32'(mon_e.src));
         chk(mon_e.name, "coord", 32'(o_coord), 32'(mon_e.coord));
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after that edge.
   task automatic cyc(input logic rst, input logic [3:0] v, input logic fz,
                      input logic [3:0] ack, input logic blank,
                      input logic [1:0] src, input logic [11:0] coord,
                      input string nm);
      exp_t e;
      i_rst    = rst;
      i_valid  = v;
      i_freeze = fz;
      @(posedge i_clk);
      #1;
      e.ack   = ack;
      e.blank = blank;
      e.src   = src;
      e.coord = coord;
      e.name  = nm;
      exp_q.push_back(e);
   endtask

   // n idle cycles showing src/coord; the first fl of them are dark when
   // flashing is built in.
   task automatic show_n(input logic [1:0] src, input logic [11:0] coord,
                         input int n, input int fl, input string nm);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 4'b0000, 1'b0, 4'b0000, FL && (i < fl), src, coord, nm);
      end
   endtask

   task automatic rst_cyc(input string nm);
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 12'h000, nm);
   endtask

   initial begin
      i_rst    = 1'b1;
      i_valid  = '0;
      i_data   = '0;
      i_freeze = 1'b0;
      @(posedge i_clk);
      #1;

      // Reset state, reset beats a valid, single source display.
      rst_cyc("reset");
      rst_cyc("reset");
      i_data[2] = 12'h1A3;
      cyc(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 12'h000, "rst_vs_valid");
      cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd0, 12'h000, "ack2");
      show_n(2'd2, 12'h1A3, 10, 0, "show2_single");

      // Two sources, 5 cycles each, alternating 0,3,0.
      rst_cyc("reset_b");
      i_data[0] = 12'h005;
      i_data[3] = 12'hFFF;
      cyc(1'b0, 4'b1001, 1'b0, 4'b1001, 1'b1, 2'd0, 12'h000, "ack03");
      show_n(2'd0, 12'h005, 5, 0, "rr_src0");
      show_n(2'd3, 12'hFFF, 5, 2, "rr_src3");
      show_n(2'd0, 12'h005, 5, 2, "rr_src0b");

      // All four at once, then freeze during source 1.
      rst_cyc("reset_c");
      i_data[0] = 12'h111;
      i_data[1] = 12'h222;
      i_data[2] = 12'h333;
      i_data[3] = 12'h444;
      cyc(1'b0, 4'b1111, 1'b0, 4'b1111, 1'b1, 2'd0, 12'h000, "ack_all");
      show_n(2'd0, 12'h111, 5, 0, "all_src0");
      show_n(2'd1, 12'h222, 2, 2, "pre_freeze");
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 12'h222, "freeze");
      end
      show_n(2'd1, 12'h222, 3, 0, "post_freeze");

      // Reset while in NEXT with every valid high.
      cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 12'h000, "rst_in_next");
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 12'h000, "no_ack_after_rst");
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 12'h000, "stay_idle");

      // New value on the shown source, repeated acks, hop to a new source.
      i_data[0] = 12'hABC;
      cyc(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 12'h000, "ack0");
      show_n(2'd0, 12'hABC, 1, 0, "show0");
      i_data[0] = 12'hDEF;
      cyc(1'b0, 4'b0001, 1'b0, 4'b0001, FL,   2'd0, 12'hDEF, "flash_new_val");
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000, FL,   2'd0, 12'hDEF, "flash_2nd");
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 12'hDEF, "flash_over");
      show_n(2'd0, 12'hDEF, 1, 0, "next_single");
      i_data[1] = 12'h123;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 12'hDEF, "multi_ack");
      end
      show_n(2'd0, 12'hDEF, 2, 0, "pre_switch");
      show_n(2'd1, 12'h123, 3, 2, "switch_to1");

      repeat (2) @(posedge i_clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_hex_display_scheduler

// File: doc/hex_display_scheduler.md
HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

Interface
REQ-001 Parameter DWELL, default 50_000_000, gives cycles each source stays on display (legal range 2..2^26).
REQ-002 Parameter FLASH_LEN, default 5_000_000, gives blanking cycles after a displayed value changes (used only with REQ-030).
REQ-003 Port i_clk, input, 1, the single clock; every register updates on its rising edge.
REQ-004 Port i_rst, input, 1, synchronous active-high reset.
REQ-005 Port i_valid, input, 4, one bit per source: source n offers i_data[n] this cycle.
REQ-006 Port i_data, input, 4x12, per-source 12-bit coordinate value.
REQ-007 Port i_freeze, input, 1, while high the current source is held and the dwell count pauses.
REQ-008 Port o_ack, output, 4, per-source one-cycle acknowledge.
REQ-009 Port o_coord, output, 12, value for the three-digit hex seven-segment decoder.
REQ-010 Port o_src, output, 2, index of the source on display.
REQ-011 Port o_blank, output, 1, high means the display is driven dark.

Function
REQ-012 Each source has its own 12-bit hold register and a present flag.
REQ-013 When i_valid[n] is high at an edge, i_data[n] is latched into hold[n], present[n] is set and o_ack[n] is high for exactly the following cycle.
REQ-014 Sources are independent: simultaneous valids on any subset are all accepted in the same cycle; a valid held high for k cycles is accepted k times, giving k acks.
REQ-015 The FSM has states IDLE, SHOW and NEXT.
REQ-016 IDLE: o_blank=1, o_coord=0, o_src=0; the FSM leaves IDLE on the first edge at which any present flag is set, entering SHOW with ptr = lowest present index and dwell count 0.
REQ-017 SHOW: o_coord=hold[ptr] (combinational from the registers, so it reflects a new value the cycle after acceptance), o_src=ptr, o_blank=0 (except REQ-030); the dwell count increments each cycle while i_freeze=0.
REQ-018 SHOW goes to NEXT on the edge where dwell count = DWELL-1 and i_freeze=0; with i_freeze=1 the count holds and the FSM stays in SHOW indefinitely.
REQ-019 NEXT lasts exactly one cycle and outputs as SHOW with the old ptr. ptr becomes the first present index after ptr, searching modulo 4 with ptr itself checked last; the FSM returns to SHOW with count 0.
REQ-020 With a single present source, ptr is unchanged across NEXT.
REQ-021 Present flags clear only on reset, so the FSM never returns to IDLE without reset.
REQ-022 Round-robin period with m present sources is m*(DWELL+1) cycles.

Reset
REQ-023 On i_rst high at an edge: state=IDLE, ptr=0, dwell count=0, all hold registers=0, all present flags=0, o_ack=0, and the flash counter=0.
REQ-024 Reset dominates i_valid in the same cycle; no ack follows a reset cycle.
REQ-025 Reset mid-SHOW or mid-NEXT gives o_blank=1, o_coord=0, o_src=0 in the next cycle.

Configuration
REQ-030 With macro HEX_SCHED_FLASH_EN defined: accepting a value for source ptr while in SHOW/NEXT, or entering SHOW from NEXT with a changed ptr, loads the flash counter with FLASH_LEN. o_blank=1 while the counter is nonzero, and the counter decrements each cycle regardless of i_freeze.
REQ-031 Without HEX_SCHED_FLASH_EN: no flash counter exists, FLASH_LEN is ignored, and o_blank is high only in IDLE.

Structure
REQ-040 Package hex_sched_pkg holds the state enum (IDLE, SHOW, NEXT), NSRC=4, COORD_W=12 and SRC_W=2.
REQ-041 Sub-module rr_next_finder computes the next present index combinationally from present[3:0] and ptr.
REQ-042 o_coord/o_src feed the existing hex decoder directly; no decode happens in this block.

Verification (DWELL=4, FLASH_LEN=2)
REQ-050 Reset, then valid[2] with 0x1A3 for one cycle -> ack[2] pulses next cycle; SHOW with o_src=2, o_coord=0x1A3, o_blank=0.
REQ-051 Present sources 0 and 3 with 0x005/0xFFF -> o_src sequence 0,3,0 with each source shown 5 cycles (4 SHOW + 1 NEXT).
REQ-052 Same cycle valid[0..3]=1111 -> four acks in the same cycle; the display starts at source 0.
REQ-053 i_freeze high for 20 cycles during SHOW of source 1 -> o_src stays 1 for 20 cycles, and the remaining dwell resumes afterward.
REQ-054 Reset asserted during NEXT -> next cycle o_blank=1, o_coord=0; acks suppressed despite valid high.
REQ-055 With HEX_SCHED_FLASH_EN, a new value on the displayed source -> o_blank high exactly 2 cycles; without the macro -> o_blank stays 0.
